riscv_v_lane_sequencer: RTL and testbench
=========================================

Name: riscv_v_lane_sequencer

Overview:
- Multi-beat element sequencer sitting between vector decode and execute/memory lanes.
- Accepts one vector op descriptor (vl, vstart, vsew, tag) and strip-mines it into DP_W-bit beats.
- For each beat it emits the base element index, a per-byte active mask and a last flag, under valid/ready backpressure.
- Successor to the fixed single-beat datapath: it generalises datapath width and SEW, honours vstart/vl boundaries, and reports resumable progress on flush.

Parameters:
- VLEN, 128, vector register length in bits.
- DP_W, 64, lane datapath width per beat in bits; a power of two, 8..VLEN.
- TAG_W, 4, width of the op tag carried through to each beat.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear_pipe  in  1  synchronous flush; aborts any op in flight.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  sequencer can accept a descriptor.
- in_vl  in  VL_W  vector length in elements; VL_W = $clog2(VLEN)+1.
- in_vstart  in  VL_W  first active element.
- in_vsew  in  3  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- in_tag  in  TAG_W  op identifier.
- beat_valid  out  1  beat outputs valid.
- beat_ready  in  1  consumer accepts the beat.
- beat_idx  out  VL_W  element index of byte 0 of the beat.
- beat_bmask  out  DP_W/8  per-byte active mask.
- beat_last  out  1  final beat of the op.
- beat_tag  out  TAG_W  tag of the current op.
- busy  out  1  op in progress (state != IDLE).
- done  out  1  one-cycle pulse: op completed normally.
- err  out  1  one-cycle pulse: op rejected.
- progress  out  VL_W  next unissued element index (vstart for resumption).

Behaviour:
- Reset (rst=0, async): state=IDLE; beat_valid, done, err, busy = 0; beat_idx, beat_bmask, beat_last, beat_tag, progress = 0; in_ready=1 once rst deasserts.
- Derived values: BPB=DP_W/8; EPB=BPB>>vsew, elements per beat.
- FSM IDLE:
  - in_ready=1. Accept when in_valid&&in_ready; the descriptor is registered.
  - If (8<<vsew)>DP_W or vsew>3: err pulses in the next cycle, no beats are issued, state stays IDLE.
  - Else if vl==0 or vstart>=vl: done pulses in the next cycle, no beats are issued, progress=vstart, state stays IDLE.
  - Else: state goes to RUN and cur=floor(vstart/EPB)*EPB; beat_valid=1 in the cycle after accept (latency 1).
- FSM RUN:
  - in_ready=0. beat_idx=cur.
  - beat_bmask byte b is set iff element e=cur+(b>>vsew) satisfies vstart<=e<vl.
  - beat_last=1 iff cur+EPB>=vl.
  - On a beat_valid&&beat_ready handshake: cur+=EPB and progress=min(cur+EPB,vl).
  - If the handshaken beat was last: state goes to IDLE, done pulses the next cycle, beat_valid drops the next cycle.
  - With beat_ready=0, all beat_* outputs are held stable; no combinational path from beat_ready to beat_* outputs.
- Arithmetic: cur is held in VL_W+1 bits so cur+EPB cannot wrap at vl=VLEN.
- clear_pipe:
  - Has priority over any handshake in the same cycle. State goes to IDLE next cycle; beat_valid=0; no done/err.
  - progress keeps the last committed value; a beat handshaken in the clear_pipe cycle is NOT committed.
  - A descriptor presented during clear_pipe is not accepted (in_ready is forced to 0 that cycle).
- Async reset mid-RUN: all outputs return immediately to reset values; no done pulse.
- No back-to-back overlap: at least one IDLE cycle separates ops (in_ready is high in the done cycle).

Decomposition:
- riscv_v_pkg additions:
  - riscv_v_sew_e enum (SEW8..SEW64).
  - riscv_v_seq_state_e (IDLE, RUN).
  - localparams BPB and VL_W.
  - riscv_v_seq_desc_t struct (vl, vstart, vsew, tag).
- Sub-module riscv_v_beat_mask_gen: purely combinational; inputs cur, vstart, vl, vsew; outputs beat_bmask and beat_last. It is reused later by the load/store unit.

Test Plan:
- DP_W=64; vsew=2, vl=5, vstart=0, beat_ready=1 -> 3 beats: idx 0/2/4, bmask 0xFF/0xFF/0x0F, beat_last on the 3rd beat, done 1 cycle later, progress=5.
- vsew=0, vl=10, vstart=3 -> 2 beats: idx 0 bmask 0xF8, then idx 8 bmask 0x03 with beat_last; done pulses; progress=10.
- vl=4, vstart=4 (and separately vl=0) -> no beat_valid, done pulses exactly 1 cycle after accept, in_ready stays 1.
- vsew=1, vl=8, beat_ready held low 3 cycles on beat 0 -> idx 0 / bmask 0xFF stable all 3 cycles; idx 4 follows only after the handshake.
- vsew=0, vl=32, clear_pipe asserted with beat_ready on the 2nd beat -> beat_valid 0 next cycle, no done, progress=8, in_ready=1.
- DP_W=32 build, vsew=3 -> err pulse, no beats. Async rst=0 mid-RUN -> beat_valid, busy, done all 0 immediately.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg
// Shared types and constants for the vector lane sequencer and its helpers.
// The descriptor struct is sized from the default VLEN / tag width below; a
// sequencer instance is expected to use the same VLEN and TAG_W as these
// defaults (DP_W may differ per instance).
package riscv_v_pkg;

    localparam int VLEN_DEF   = 128;
    localparam int DP_W_DEF   = 64;
    localparam int DESC_TAG_W = 4;

    // Bytes per beat and element-count width for the default configuration.
    localparam int BPB  = DP_W_DEF / 8;
    localparam int VL_W = $clog2(VLEN_DEF) + 1;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } riscv_v_sew_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } riscv_v_seq_state_e;

    typedef struct packed {
        logic [VL_W-1:0]       vl;
        logic [VL_W-1:0]       vstart;
        riscv_v_sew_e          vsew;
        logic [DESC_TAG_W-1:0] tag;
    } riscv_v_seq_desc_t;

endpackage

// File: rtl/riscv_v_beat_mask_gen.sv
// riscv_v_beat_mask_gen
// Purely combinational per-byte active mask and last-beat flag for one
// DP_W-bit beat whose byte 0 holds element 'cur'.
// Ports:
//   cur        in  VL_W+1  element index of byte 0 of the beat
//   vstart     in  VL_W    first active element
//   vl         in  VL_W    vector length (one past last active element)
//   vsew       in  3       element width code (0=8b .. 3=64b), must be legal
//   beat_bmask out DP_W/8  byte b set iff vstart <= cur+(b>>vsew) < vl
//   beat_last  out 1       cur + elements-per-beat >= vl
module riscv_v_beat_mask_gen #(
    parameter int VL_W = 8,
    parameter int DP_W = 64
) (
    input  logic [VL_W:0]       cur,
    input  logic [VL_W-1:0]     vstart,
    input  logic [VL_W-1:0]     vl,
    input  logic [2:0]          vsew,
    output logic [DP_W/8-1:0]   beat_bmask,
    output logic                beat_last
);

    localparam int BPB_L = DP_W / 8;
    // Two extra bits so cur plus an in-beat offset never wraps.
    localparam int EW    = VL_W + 2;

    logic [EW-1:0] elem;
    logic [EW-1:0] epb;

    always_comb begin
        beat_bmask = '0;
        elem       = '0;
        epb        = EW'(BPB_L) >> vsew;
        for (int b = 0; b < BPB_L; b++) begin
            elem          = EW'(cur) + (EW'(b) >> vsew);
            beat_bmask[b] = (elem >= EW'(vstart)) && (elem < EW'(vl));
        end
        beat_last = (EW'(cur) + epb) >= EW'(vl);
    end

endmodule

// File: rtl/riscv_v_lane_sequencer.sv
// riscv_v_lane_sequencer
// Accepts one vector op descriptor and strip-mines it into DP_W-bit beats,
// each carrying its base element index, per-byte active mask and last flag.
// Ports:
//   clk, rst (async, active-low)
//   clear_pipe            synchronous flush of the op in flight
//   in_valid/in_ready     descriptor handshake; in_vl, in_vstart, in_vsew, in_tag
//   beat_valid/beat_ready beat handshake; beat_idx, beat_bmask, beat_last, beat_tag
//   busy                  op in progress
//   done / err            one-cycle completion / rejection pulses
//   progress              next unissued element (resume point after a flush)
module riscv_v_lane_sequencer
    import riscv_v_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int DP_W  = 64,
    parameter int TAG_W = 4,
    localparam int VLW  = $clog2(VLEN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_pipe,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VLW-1:0]      in_vl,
    input  logic [VLW-1:0]      in_vstart,
    input  logic [2:0]          in_vsew,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                beat_valid,
    input  logic                beat_ready,
    output logic [VLW-1:0]      beat_idx,
    output logic [DP_W/8-1:0]   beat_bmask,
    output logic                beat_last,
    output logic [TAG_W-1:0]    beat_tag,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [VLW-1:0]      progress
);

    localparam int BPB_L   = DP_W / 8;
    // Widest legal SEW code: element must fit in one beat, and the ISA caps it at 64b.
    localparam int MAX_SEW = ($clog2(BPB_L) > 3) ? 3 : $clog2(BPB_L);
    localparam logic [VLW:0] BPB_W = (VLW+1)'(BPB_L);

    riscv_v_seq_state_e state_q, state_d;
    riscv_v_seq_desc_t  desc_q, desc_d;
    logic [VLW:0]       cur_q, cur_d;
    logic [VLW-1:0]     progress_q, progress_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               run;
    logic               in_sew_ok;
    logic [VLW:0]       in_epb;
    logic [VLW:0]       in_start;
    logic [VLW:0]       epb;
    logic [VLW:0]       cur_nxt;
    logic [BPB_L-1:0]   bmask_w;
    logic               last_w;

    assign run       = (state_q == RUN);
    assign in_sew_ok = (in_vsew <= 3'(MAX_SEW));
    assign in_epb    = BPB_W >> in_vsew;
    // EPB is a power of two, so aligning vstart down is a mask of its low bits.
    assign in_start  = {1'b0, in_vstart} & ~(in_epb - (VLW+1)'(1));
    assign epb       = BPB_W >> desc_q.vsew;
    assign cur_nxt   = cur_q + epb;

    // Flush wins over a new descriptor; nothing is accepted while in reset.
    assign in_ready  = rst && !clear_pipe && (state_q == IDLE);

    riscv_v_beat_mask_gen #(
        .VL_W (VLW),
        .DP_W (DP_W)
    ) u_mask (
        .cur        (cur_q),
        .vstart     (desc_q.vstart),
        .vl         (desc_q.vl),
        .vsew       ({1'b0, desc_q.vsew}),
        .beat_bmask (bmask_w),
        .beat_last  (last_w)
    );

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        cur_d      = cur_q;
        progress_d = progress_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (!in_sew_ok) begin
                        err_d = 1'b1;
                    end else if ((in_vl == '0) || (in_vstart >= in_vl)) begin
                        done_d     = 1'b1;
                        progress_d = in_vstart;
                    end else begin
                        state_d       = RUN;
                        desc_d.vl     = in_vl;
                        desc_d.vstart = in_vstart;
                        desc_d.vsew   = riscv_v_sew_e'(in_vsew[1:0]);
                        desc_d.tag    = DESC_TAG_W'(in_tag);
                        cur_d         = in_start;
                        progress_d    = in_vstart;
                    end
                end
            end
            RUN: begin
                if (clear_pipe) begin
                    // A beat handshaken in this cycle is dropped, not committed.
                    state_d = IDLE;
                end else if (beat_ready) begin
                    cur_d      = cur_nxt;
                    progress_d = (cur_nxt >= {1'b0, desc_q.vl}) ? desc_q.vl
                                                                 : cur_nxt[VLW-1:0];
                    if (last_w) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            progress_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Descriptor and element cursor are only observed while RUN, so no reset.
    always_ff @(posedge clk) begin
        desc_q <= desc_d;
        cur_q  <= cur_d;
    end

    // Beat outputs derive from registered state only; beat_ready never reaches them.
    assign beat_valid = run;
    assign busy       = run;
    assign beat_idx   = run ? cur_q[VLW-1:0] : '0;
    assign beat_bmask = run ? bmask_w : '0;
    assign beat_last  = run && last_w;
    assign beat_tag   = run ? TAG_W'(desc_q.tag) : '0;
    assign done       = done_q;
    assign err        = err_q;
    assign progress   = progress_q;

endmodule

// File: tb/tb_riscv_v_lane_sequencer.sv
module tb_riscv_v_lane_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_pipe = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_valid32 = 1'b0;
    logic       beat_ready = 1'b0;
    logic [7:0] in_vl = '0;
    logic [7:0] in_vstart = '0;
    logic [2:0] in_vsew = '0;
    logic [3:0] in_tag = '0;

    logic       in_ready, beat_valid, beat_last, busy, done, err;
    logic [7:0] beat_idx, beat_bmask, progress;
    logic [3:0] beat_tag;

    logic       in_ready32, beat_valid32, beat_last32, busy32, done32, err32;
    logic [7:0] beat_idx32, progress32;
    logic [3:0] beat_bmask32, beat_tag32;

    riscv_v_lane_sequencer #(.VLEN(128), .DP_W(64), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .clear_pipe(clear_pipe),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vl(in_vl), .in_vstart(in_vstart), .in_vsew(in_vsew), .in_tag(in_tag),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_idx(beat_idx), .beat_bmask(beat_bmask), .beat_last(beat_last),
        .beat_tag(beat_tag), .busy(busy), .done(done), .err(err),
        .progress(progress)
    );

    riscv_v_lane_sequencer #(.VLEN(128), .DP_W(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst(rst), .clear_pipe(clear_pipe),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .in_vl(in_vl), .in_vstart(in_vstart), .in_vsew(in_vsew), .in_tag(in_tag),
        .beat_valid(beat_valid32), .beat_ready(beat_ready),
        .beat_idx(beat_idx32), .beat_bmask(beat_bmask32), .beat_last(beat_last32),
        .beat_tag(beat_tag32), .busy(busy32), .done(done32), .err(err32),
        .progress(progress32)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]       vl;
        logic [7:0]       vstart;
        logic [2:0]       vsew;
        logic [3:0]       tag;
        int               nb;
        bit               is_err;
        logic [2:0][7:0]  idx;
        logic [2:0][7:0]  bm;
        logic [7:0]       prog;
    } vec_t;

    function automatic vec_t mkv(input logic [7:0] vl, input logic [7:0] vs,
                                 input logic [2:0] sew, input logic [3:0] tag,
                                 input int nb, input bit is_err,
                                 input logic [7:0] i0, input logic [7:0] i1,
                                 input logic [7:0] i2, input logic [7:0] m0,
                                 input logic [7:0] m1, input logic [7:0] m2,
                                 input logic [7:0] prog);
        vec_t v;
        v.vl = vl; v.vstart = vs; v.vsew = sew; v.tag = tag;
        v.nb = nb; v.is_err = is_err;
        v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2;
        v.bm[0]  = m0; v.bm[1]  = m1; v.bm[2]  = m2;
        v.prog = prog;
        return v;
    endfunction

    localparam int NV = 8;
    vec_t vecs[NV];

    initial begin
        //                vl    vs    sew tag nb err  idx0   idx1  idx2   bm0    bm1    bm2   prog
        vecs[0] = mkv(8'd5,   8'd0,   3'd2, 4'd1, 3, 0, 8'd0,   8'd2, 8'd4, 8'hFF, 8'hFF, 8'h0F, 8'd5);
        vecs[1] = mkv(8'd10,  8'd3,   3'd0, 4'd2, 2, 0, 8'd0,   8'd8, 8'd0, 8'hF8, 8'h03, 8'h00, 8'd10);
        vecs[2] = mkv(8'd4,   8'd4,   3'd0, 4'd3, 0, 0, 8'd0,   8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'd4);
        vecs[3] = mkv(8'd0,   8'd0,   3'd1, 4'd4, 0, 0, 8'd0,   8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'd0);
        vecs[4] = mkv(8'd3,   8'd1,   3'd3, 4'd5, 2, 0, 8'd1,   8'd2, 8'd0, 8'hFF, 8'hFF, 8'h00, 8'd3);
        vecs[5] = mkv(8'd7,   8'd5,   3'd1, 4'd6, 1, 0, 8'd4,   8'd0, 8'd0, 8'h3C, 8'h00, 8'h00, 8'd7);
        vecs[6] = mkv(8'd128, 8'd120, 3'd0, 4'd7, 1, 0, 8'd120, 8'd0, 8'd0, 8'hFF, 8'h00, 8'h00, 8'd128);
        vecs[7] = mkv(8'd9,   8'd0,   3'd5, 4'd8, 0, 1, 8'd0,   8'd0, 8'd0, 8'h00, 8'h00, 8'h00, 8'd128);

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst beat_valid", 32'(beat_valid), 0);
        chk("rst busy",       32'(busy), 0);
        chk("rst done",       32'(done), 0);
        chk("rst err",        32'(err), 0);
        chk("rst progress",   32'(progress), 0);
        chk("rst beat_idx",   32'(beat_idx), 0);
        chk("rst beat_bmask", 32'(beat_bmask), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();
        chk("post-rst in_ready", 32'(in_ready), 1);

        // Table-driven ops, consumer always ready
        beat_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_vl = vecs[i].vl; in_vstart = vecs[i].vstart;
            in_vsew = vecs[i].vsew; in_tag = vecs[i].tag;
            in_valid = 1'b1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 1);
            step();
            in_valid = 1'b0;
            if (vecs[i].is_err) begin
                chk($sformatf("v%0d err", i),        32'(err), 1);
                chk($sformatf("v%0d done", i),       32'(done), 0);
                chk($sformatf("v%0d beat_valid", i), 32'(beat_valid), 0);
                chk($sformatf("v%0d busy", i),       32'(busy), 0);
                chk($sformatf("v%0d progress", i),   32'(progress), 32'(vecs[i].prog));
            end else begin
                for (int k = 0; k < vecs[i].nb; k++) begin
                    chk($sformatf("v%0d b%0d valid", i, k), 32'(beat_valid), 1);
                    chk($sformatf("v%0d b%0d idx", i, k),   32'(beat_idx), 32'(vecs[i].idx[k]));
                    chk($sformatf("v%0d b%0d bmask", i, k), 32'(beat_bmask), 32'(vecs[i].bm[k]));
                    chk($sformatf("v%0d b%0d last", i, k),  32'(beat_last),
                        (k == vecs[i].nb - 1) ? 32'd1 : 32'd0);
                    chk($sformatf("v%0d b%0d tag", i, k),   32'(beat_tag), 32'(vecs[i].tag));
                    step();
                end
                chk($sformatf("v%0d done", i),       32'(done), 1);
                chk($sformatf("v%0d beat_valid", i), 32'(beat_valid), 0);
                chk($sformatf("v%0d progress", i),   32'(progress), 32'(vecs[i].prog));
                chk($sformatf("v%0d in_ready", i),   32'(in_ready), 1);
            end
            step();
            chk($sformatf("v%0d done pulse", i), 32'(done), 0);
            chk($sformatf("v%0d err pulse", i),  32'(err), 0);
        end

        // Backpressure: beat 0 held for 3 cycles
        beat_ready = 1'b0;
        in_vl = 8'd8; in_vstart = 8'd0; in_vsew = 3'd1; in_tag = 4'd10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("bp c%0d valid", j), 32'(beat_valid), 1);
            chk($sformatf("bp c%0d idx", j),   32'(beat_idx), 0);
            chk($sformatf("bp c%0d bmask", j), 32'(beat_bmask), 32'hFF);
            chk($sformatf("bp c%0d last", j),  32'(beat_last), 0);
            step();
        end
        beat_ready = 1'b1;
        step();
        chk("bp b1 idx",   32'(beat_idx), 4);
        chk("bp b1 bmask", 32'(beat_bmask), 32'hFF);
        chk("bp b1 last",  32'(beat_last), 1);
        step();
        chk("bp done",     32'(done), 1);
        chk("bp progress", 32'(progress), 8);
        step();

        // clear_pipe during the 2nd beat handshake
        in_vl = 8'd32; in_vstart = 8'd0; in_vsew = 3'd0; in_tag = 4'd11;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("clr b0 idx", 32'(beat_idx), 0);
        step();
        chk("clr b1 idx",   32'(beat_idx), 8);
        chk("clr b1 valid", 32'(beat_valid), 1);
        clear_pipe = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("clr in_ready forced", 32'(in_ready), 0);
        step();
        clear_pipe = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr beat_valid", 32'(beat_valid), 0);
        chk("clr busy",       32'(busy), 0);
        chk("clr done",       32'(done), 0);
        chk("clr progress",   32'(progress), 8);
        chk("clr in_ready",   32'(in_ready), 1);
        step();
        chk("clr done later", 32'(done), 0);
        chk("clr busy later", 32'(busy), 0);

        // DP_W=32 instance: 64-bit SEW rejected, 32-bit SEW accepted
        in_vl = 8'd4; in_vstart = 8'd0; in_vsew = 3'd3; in_tag = 4'd12;
        in_valid32 = 1'b1;
        step();
        in_valid32 = 1'b0;
        chk("d32 err",        32'(err32), 1);
        chk("d32 beat_valid", 32'(beat_valid32), 0);
        chk("d32 busy",       32'(busy32), 0);
        chk("d32 main idle",  32'(busy), 0);
        step();
        chk("d32 err pulse",  32'(err32), 0);
        in_vl = 8'd1; in_vstart = 8'd0; in_vsew = 3'd2; in_tag = 4'd9;
        in_valid32 = 1'b1;
        step();
        in_valid32 = 1'b0;
        chk("d32 b0 valid", 32'(beat_valid32), 1);
        chk("d32 b0 idx",   32'(beat_idx32), 0);
        chk("d32 b0 bmask", 32'(beat_bmask32), 32'hF);
        chk("d32 b0 last",  32'(beat_last32), 1);
        chk("d32 b0 tag",   32'(beat_tag32), 9);
        step();
        chk("d32 done",     32'(done32), 1);
        chk("d32 progress", 32'(progress32), 1);
        step();

        // Async reset in the middle of an op
        beat_ready = 1'b0;
        in_vl = 8'd32; in_vstart = 8'd5; in_vsew = 3'd0; in_tag = 4'd13;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("arst pre busy",     32'(busy), 1);
        chk("arst pre progress", 32'(progress), 5);
        #2 rst = 1'b0;
        #1;
        chk("arst beat_valid", 32'(beat_valid), 0);
        chk("arst busy",       32'(busy), 0);
        chk("arst done",       32'(done), 0);
        chk("arst progress",   32'(progress), 0);
        chk("arst beat_bmask", 32'(beat_bmask), 0);
        @(negedge clk) rst = 1'b1;
        step();
        chk("arst after done",     32'(done), 0);
        chk("arst after busy",     32'(busy), 0);
        chk("arst after in_ready", 32'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
